// File: rtl/register_bank.sv
// register_bank: DEPTH general-purpose registers of WIDTH bits with one
// modify port (LOAD/INC/DEC/SHL/SHR/CLR), two combinational read ports,
// registered zero/carry flags and a multi-cycle clear-all sweep.
// Optional build macro: REGBANK_BYPASS_EN adds write-through read bypass.
// The reset input is asynchronous and active-low (0 = reset).
module register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_all,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic             wr_addr_ok;
    logic             op_active;
    logic             op_exec;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] op_result;
    logic             op_carry;

    // Decode the requested op and compute its result and carry from the target register.
    always_comb begin
        wr_addr_ok = (32'(wr_addr) < DEPTH);
        old_val    = '0;
        if (wr_addr_ok) begin
            old_val = regs_q[wr_addr];
        end
        op_active = 1'b1;
        op_result = old_val;
        op_carry  = 1'b0;
        case (op)
            OP_LOAD: op_result = wr_data;
            OP_INC:  {op_carry, op_result} = {1'b0, old_val} + (WIDTH + 1)'(1);
            OP_DEC: begin
                op_result = old_val - WIDTH'(1);
                op_carry  = (old_val == '0);
            end
            OP_SHL: begin
                op_result = {old_val[WIDTH-2:0], 1'b0};
                op_carry  = old_val[WIDTH-1];
            end
            OP_SHR: begin
                op_result = {1'b0, old_val[WIDTH-1:1]};
                op_carry  = old_val[0];
            end
            OP_CLR:  op_result = '0;
            default: op_active = 1'b0;
        endcase
        // A clear-all request wins over a simultaneous op, and nothing executes mid-sweep.
        op_exec = (state_q == IDLE) && !clr_all && wr_addr_ok && op_active;
    end

    // Next-state logic: op execution in IDLE, one register cleared per cycle in SWEEP.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            IDLE: begin
                if (clr_all) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end else if (op_exec) begin
                    regs_d[wr_addr] = op_result;
                    zero_d          = (op_result == '0);
                    carry_d         = op_carry;
                end
            end
            SWEEP: begin
                regs_d[idx_q] = '0;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    carry_d = 1'b0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, register array and flags; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: stored contents, zero for unpopulated addresses, optional write-through.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (32'(rd_addr_a) < DEPTH) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (32'(rd_addr_b) < DEPTH) begin
            rd_data_b = regs_q[rd_addr_b];
        end
`ifdef REGBANK_BYPASS_EN
        if (op_exec && (rd_addr_a == wr_addr)) begin
            rd_data_a = op_result;
        end
        if (op_exec && (rd_addr_b == wr_addr)) begin
            rd_data_b = op_result;
        end
`endif
    end

    assign zero  = zero_q;
    assign carry = carry_q;
    assign busy  = (state_q == SWEEP);

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the single externally controlled 8-bit register.
- DEPTH registers of WIDTH bits, one modify port and two independent read ports.
- The modify port applies per-cycle operations: load, inc, dec, shl, shr, clr.
- Registered zero/carry flags and a multi-cycle clear-all sweep with a busy indication.
- Feeds the datapath as the general-purpose register set; controlled by the sequencer.

Parameters:
WIDTH, 8, bits per register (>=2)
DEPTH, 4, number of registers (>=2, need not be a power of two)
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
op  in  3  000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 SHL, 101 SHR, 110 CLR, 111 reserved (treated as NOP)
wr_addr  in  AW  target register of op
wr_data  in  WIDTH  operand for LOAD
clr_all  in  1  one-cycle request to start the clear-all sweep
rd_addr_a  in  AW  read port A address
rd_addr_b  in  AW  read port B address
rd_data_a  out  WIDTH  read port A data (combinational from array)
rd_data_b  out  WIDTH  read port B data
zero  out  1  registered: last executed op result == 0
carry  out  1  registered: carry/borrow/shifted-out bit of last executed op
busy  out  1  high while the clear-all sweep runs

Behaviour:
- Reset (reset=0, any time, including mid-sweep):
  - All registers = 0; zero = 0, carry = 0, busy = 0.
  - FSM returns to IDLE.
  - Takes effect immediately, without waiting for a clock edge.
- FSM: IDLE, SWEEP.
  - IDLE + clr_all=1: enter SWEEP; sweep index = 0; busy=1 from the next cycle.
  - SWEEP: each cycle clears register[index] and increments index.
  - After clearing index DEPTH-1: return to IDLE; busy=0 in the following cycle.
  - busy is high for exactly DEPTH cycles.
  - On completion: zero=1, carry=0.
  - clr_all while busy: ignored.
- Op execution (IDLE only; one op per cycle; result written at the clock edge; latency 1):
  - LOAD: reg=wr_data; carry=0.
  - INC: reg=reg+1 mod 2^WIDTH; carry=1 iff old value all ones.
  - DEC: reg=reg-1 mod 2^WIDTH; carry=1 iff old value 0 (borrow).
  - SHL: reg={reg[WIDTH-2:0],0}; carry=old msb.
  - SHR: reg={0,reg[WIDTH-1:1]}; carry=old lsb.
  - CLR: reg=0; carry=0.
  - Every executed non-NOP op updates zero from its result.
  - NOP/reserved: no register or flag change.
- Simultaneous events:
  - clr_all=1 with a non-NOP op in IDLE: sweep starts and the op is dropped (no register or flag change).
  - Ops presented while busy are dropped; the caller retries after busy falls.
- Addresses >= DEPTH:
  - Ops to them: no register change, flags unchanged.
  - Reads of them: return 0.
- Reads:
  - Combinational from the stored array; both ports may read the same address.
  - Without the optional feature, a read shows the pre-edge value in the cycle an op targets that address.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined: when an op executes this cycle and rd_addr_x == wr_addr (valid address), rd_data_x shows the op's result combinationally in the same cycle (write-through bypass). Not active during SWEEP.
- Undefined: no bypass; reads always reflect stored contents.

Test Plan:
- Release reset, LOAD r2=0xA5, then read A=r2 and B=r2 -> both 0xA5, zero=0, carry=0; r0, r1, r3 = 0.
- LOAD r1=0xFF, INC r1 -> r1=0x00, zero=1, carry=1; DEC r1 -> 0xFF, carry=1, zero=0.
- LOAD r3=0x81; SHL -> 0x02, carry=1; SHR -> 0x01, carry=0; SHR -> 0x00, carry=1, zero=1.
- Load all registers nonzero, pulse clr_all together with op=LOAD r0=0x55:
  - LOAD dropped; busy high exactly 4 cycles.
  - INC during busy ignored.
  - Afterwards all registers 0, zero=1, carry=0.
- Assert reset at the 2nd cycle of a sweep -> busy=0 and all registers 0 immediately, without a clock edge; LOAD next cycle after release executes normally.
- DEPTH=5, AW=3: LOAD r6 -> no change, flags held, read r6=0. With REGBANK_BYPASS_EN: LOAD r0=0x3C with rd_addr_a=0 -> rd_data_a=0x3C in the same cycle.
